aes_byte_loader: RTL and testbench
==================================

Name: aes_byte_loader

Overview:
Upstream feeder for the byte-serial AES-128 encryption core. Collects plaintext and key bytes from a host using a valid/ready write handshake into two 16-byte buffers. On a start command it releases the core from reset and streams both buffers to the core in lockstep, one byte per clock, for 16 consecutive cycles. It then waits out the core's computation time before accepting a new block.

Parameters:
NBYTES, 16, bytes per block (plaintext and key each).
RST_CYCLES, 2, cycles the core is held in reset before streaming.
RUN_CYCLES, 160, cycles after the last streamed byte before returning to IDLE.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  host byte write request
wr_ready  out  1  loader can accept the write (depends on wr_sel)
wr_sel  in  1  0 = plaintext buffer, 1 = key buffer
wr_data  in  8  byte to write; AES byte 0 is written first
start  in  1  single-cycle request to begin encryption
start_err  out  1  one-cycle pulse: start seen while not IDLE or buffers not full
pt_byte  out  8  plaintext byte to the core (drives core ui_in)
key_byte  out  8  key byte to the core (drives core uio_in)
core_rst_n  out  1  active-low reset to the core, registered
busy  out  1  high in any state other than IDLE
stream_first  out  1  high during the cycle byte 0 is presented

Behaviour:
- Reset is synchronous on clk: rst=1 forces the following.
  - state=IDLE; both write pointers = 0.
  - core_rst_n=0; pt_byte=key_byte=0.
  - busy=0, start_err=0, stream_first=0.
- Reset mid-operation (any state) aborts immediately with the same values. Buffer contents are don't-care.
- Write handshake:
  - wr_ready = (state==IDLE) && (ptr[wr_sel] < NBYTES).
  - A byte is accepted on a rising edge where wr_valid && wr_ready. buf[wr_sel][ptr] <= wr_data, and ptr increments.
  - A write to a full buffer is not accepted and is not an error; the pointer saturates at NBYTES.
- State machine:
  - IDLE
    - Writes allowed.
    - core_rst_n keeps its last value, so the core's output stays observable after a run.
    - If start && ptr_pt==NBYTES && ptr_key==NBYTES: go to RESET, core_rst_n<=0, counter=0.
    - If start otherwise: start_err pulses for one cycle and the state stays IDLE.
  - RESET
    - core_rst_n=0 for exactly RST_CYCLES cycles, then go to STREAM.
    - The transition sets core_rst_n<=1 and index i=0 in the same edge.
  - STREAM
    - Lasts 16 cycles, i = 0..15; core_rst_n=1.
    - pt_byte=buf_pt[i], key_byte=buf_key[i], both registered.
    - The first cycle with core_rst_n=1 presents byte 0; stream_first=1 only in that cycle.
    - After i=15, go to RUN with counter=0.
  - RUN
    - pt_byte=key_byte=0; core_rst_n=1.
    - Counts RUN_CYCLES cycles, then goes to IDLE and clears both pointers to 0.
    - Buffer contents are retained but must be rewritten before the next start.
- start while busy: ignored, start_err pulses.
- A write and start in the same IDLE cycle: start is evaluated against the pointer values before the write.
- Counters are sized to hold max(RST_CYCLES, RUN_CYCLES, NBYTES). No wrap is possible because every count is bounded by a state exit.
- Latency: start at edge N gives core_rst_n low from N+1. Byte 0 is presented at N+1+RST_CYCLES and byte 15 at N+16+RST_CYCLES.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NBYTES=16;
  - state encoding IDLE/RESET/STREAM/RUN (2 bits);
  - SEL_PT=0, SEL_KEY=1.
- Natural sub-module: aes_byte_buf16. It is a 16x8 register file with a saturating write pointer, a full flag, a pointer clear, and an asynchronous read by index. It is instantiated twice, once for plaintext and once for key.

Test Plan:
- FIPS-197 vector: write pt 00 11 22 .. ff and key 00 01 02 .. 0f, then start.
  - core_rst_n is low for 2 cycles.
  - Then 16 cycles show pt_byte/key_byte pairs (00,00), (11,01), .. (ff,0f); stream_first is high only for the first pair.
  - busy drops 160 cycles after the last byte. The core's output matches 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
- Start with only 15 key bytes written: start_err=1 for 1 cycle, state stays IDLE, core_rst_n unchanged.
- Write a 17th plaintext byte (aa): wr_ready=0 for wr_sel=0 while key writes are still accepted; streamed plaintext byte 15 is the 16th byte written, not aa.
- Start pulse during STREAM: start_err pulses, and streaming continues uninterrupted with no byte skipped.
- Assert rst during STREAM at i=7: the next cycle has core_rst_n=0, pt_byte=key_byte=0, busy=0, wr_ready=1.
- Back-to-back blocks: after RUN completes, pointers read 0. A second 32-byte load plus start streams the new data, and the first block's bytes never reappear.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the byte-serial AES loader: block size, FSM encoding,
// and write-select codes.
package aes_pkg;

    localparam int AES_NBYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESET  = 2'd1,
        ST_STREAM = 2'd2,
        ST_RUN    = 2'd3
    } aes_state_e;

    localparam logic SEL_PT  = 1'b0;
    localparam logic SEL_KEY = 1'b1;

endpackage

// File: rtl/aes_byte_buf16.sv
// Byte register file with a saturating write pointer and asynchronous read.
// Contents survive reset; only the pointer is cleared.
module aes_byte_buf16
    import aes_pkg::*;
#(
    parameter  int NBYTES = AES_NBYTES,
    localparam int IW     = $clog2(NBYTES),
    localparam int PW     = $clog2(NBYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [7:0]    wdata_i,
    input  logic [IW-1:0] ridx_i,
    output logic [7:0]    rdata_o,
    output logic          full_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [7:0]    mem_q [NBYTES];
    logic          accept;

    assign full_o  = (ptr_q == PW'(NBYTES));
    assign accept  = we_i && !full_o;
    assign rdata_o = mem_q[ridx_i];

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (accept) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[ptr_q[IW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/aes_byte_loader.sv
// Collects plaintext/key bytes from the host, then resets the AES core and
// streams both blocks to it one byte per clock before waiting out its run time.
module aes_byte_loader
    import aes_pkg::*;
#(
    parameter int NBYTES     = AES_NBYTES,
    parameter int RST_CYCLES = 2,
    parameter int RUN_CYCLES = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       start_err,
    output logic [7:0] pt_byte,
    output logic [7:0] key_byte,
    output logic       core_rst_n,
    output logic       busy,
    output logic       stream_first
);

    localparam int IW   = $clog2(NBYTES);
    localparam int CMX0 = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int CMAX = (CMX0 > NBYTES) ? CMX0 : NBYTES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

    aes_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    pt_q, pt_d;
    logic [7:0]    key_q, key_d;
    logic          crn_q, crn_d;
    logic          serr_q, serr_d;

    logic          clr;
    logic [IW-1:0] rd_idx;
    logic [7:0]    pt_rd, key_rd;
    logic          pt_full, key_full;
    logic          pt_we, key_we;

    assign wr_ready = (state_q == ST_IDLE) && !((wr_sel == SEL_KEY) ? key_full : pt_full);
    assign pt_we    = wr_valid && wr_ready && (wr_sel == SEL_PT);
    assign key_we   = wr_valid && wr_ready && (wr_sel == SEL_KEY);

    aes_byte_buf16 #(.NBYTES(NBYTES)) u_pt_buf (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .we_i    (pt_we),
        .wdata_i (wr_data),
        .ridx_i  (rd_idx),
        .rdata_o (pt_rd),
        .full_o  (pt_full)
    );

    aes_byte_buf16 #(.NBYTES(NBYTES)) u_key_buf (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .we_i    (key_we),
        .wdata_i (wr_data),
        .ridx_i  (rd_idx),
        .rdata_o (key_rd),
        .full_o  (key_full)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pt_d    = pt_q;
        key_d   = key_q;
        crn_d   = crn_q;
        serr_d  = 1'b0;
        clr     = 1'b0;
        rd_idx  = '0;

        if (start && state_q != ST_IDLE) begin
            serr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (pt_full && key_full) begin
                        state_d = ST_RESET;
                        crn_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        serr_d = 1'b1;
                    end
                end
            end
            ST_RESET: begin
                crn_d = 1'b0;
                if (cnt_q == RST_LAST) begin
                    // Byte 0 is loaded on the same edge that releases the core.
                    state_d = ST_STREAM;
                    crn_d   = 1'b1;
                    idx_d   = '0;
                    rd_idx  = '0;
                    pt_d    = pt_rd;
                    key_d   = key_rd;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STREAM: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    pt_d    = '0;
                    key_d   = '0;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    rd_idx = idx_q + 1'b1;
                    pt_d   = pt_rd;
                    key_d  = key_rd;
                end
            end
            ST_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    state_d = ST_IDLE;
                    clr     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pt_q    <= '0;
            key_q   <= '0;
            crn_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            crn_q   <= crn_d;
            serr_q  <= serr_d;
        end
    end

    assign pt_byte      = pt_q;
    assign key_byte     = key_q;
    assign core_rst_n   = crn_q;
    assign start_err    = serr_q;
    assign busy         = (state_q != ST_IDLE);
    assign stream_first = (state_q == ST_STREAM) && (idx_q == '0);

endmodule

// File: tb/tb_aes_byte_loader.sv
// Directed bench for aes_byte_loader: load/stream/run timing, full-buffer and
// start-error handling, mid-stream reset, back-to-back blocks.
module tb_aes_byte_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_sel = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       start = 1'b0;
    logic       wr_ready, start_err, core_rst_n, busy, stream_first;
    logic [7:0] pt_byte, key_byte;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_pt  [16];
    logic [7:0] exp_key [16];

    always #5 clk = ~clk;

    aes_byte_loader #(.NBYTES(16), .RST_CYCLES(2), .RUN_CYCLES(160)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .start        (start),
        .start_err    (start_err),
        .pt_byte      (pt_byte),
        .key_byte     (key_byte),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .stream_first (stream_first)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic sel, input logic [7:0] d);
        wr_sel   = sel;
        wr_data  = d;
        wr_valid = 1'b1;
        #1;
        check("wr_ready_on_write", wr_ready, 1);
        tick;
        wr_valid = 1'b0;
    endtask

    task automatic load_block(input int unsigned n_key);
        for (int unsigned i = 0; i < 16; i++) write_byte(1'b0, exp_pt[i]);
        for (int unsigned i = 0; i < n_key; i++) write_byte(1'b1, exp_key[i]);
    endtask

    // start_at >= 0 pulses start on the edge that presents that byte index
    task automatic stream_block(input int start_at);
        int n;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("core_rst_n_low_c0", core_rst_n, 0);
        check("busy_in_reset", busy, 1);
        tick;
        check("core_rst_n_low_c1", core_rst_n, 0);
        for (int unsigned i = 0; i < 16; i++) begin
            if (int'(i) == start_at) start = 1'b1;
            tick;
            start = 1'b0;
            check("core_rst_n_stream", core_rst_n, 1);
            check($sformatf("pt_byte[%0d]", i), pt_byte, exp_pt[i]);
            check($sformatf("key_byte[%0d]", i), key_byte, exp_key[i]);
            check($sformatf("stream_first[%0d]", i), stream_first, (i == 0) ? 1 : 0);
            if (int'(i) == start_at) check("start_err_in_stream", start_err, 1);
        end
        n = 0;
        for (int unsigned k = 0; k < 400; k++) begin
            tick;
            if (k == 0) begin
                check("pt_byte_run", pt_byte, 0);
                check("key_byte_run", key_byte, 0);
            end
            if (!busy) break;
            n++;
        end
        check("run_busy_cycles", n, 160);
        check("core_rst_n_held_idle", core_rst_n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        tick;
        tick;
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_pt_byte", pt_byte, 0);
        check("rst_key_byte", key_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_start_err", start_err, 0);
        check("rst_stream_first", stream_first, 0);
        check("rst_wr_ready", wr_ready, 1);
        rst = 1'b0;
        tick;

        // FIPS-197 block: pt 00 11 .. ff, key 00 01 .. 0f; only 15 key bytes first
        for (int unsigned i = 0; i < 16; i++) begin
            exp_pt[i]  = 8'(i * 8'h11);
            exp_key[i] = 8'(i);
        end
        load_block(15);

        // 17th plaintext byte refused while key side still open
        wr_sel   = 1'b0;
        wr_data  = 8'haa;
        wr_valid = 1'b1;
        #1;
        check("wr_ready_pt_full", wr_ready, 0);
        wr_sel = 1'b1;
        #1;
        check("wr_ready_key_open", wr_ready, 1);
        wr_sel = 1'b0;
        tick;
        wr_valid = 1'b0;

        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_err_key15", start_err, 1);
        check("busy_key15", busy, 0);
        check("core_rst_n_key15", core_rst_n, 0);
        tick;
        check("start_err_one_cycle", start_err, 0);
        check("busy_still_idle", busy, 0);

        write_byte(1'b1, 8'h0f);
        stream_block(5);

        wr_sel = 1'b0;
        #1;
        check("wr_ready_pt_after_run", wr_ready, 1);
        wr_sel = 1'b1;
        #1;
        check("wr_ready_key_after_run", wr_ready, 1);

        // Pointers cleared: start on empty buffers must be refused
        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_err_empty", start_err, 1);
        check("busy_empty", busy, 0);
        check("core_rst_n_unchanged", core_rst_n, 1);

        // Second block, distinct data
        for (int unsigned i = 0; i < 16; i++) begin
            exp_pt[i]  = 8'(8'hf0 - i);
            exp_key[i] = 8'(8'h3c ^ (i * 8'h10));
        end
        load_block(16);
        stream_block(-1);

        // Third block, reset asserted while byte 7 is presented
        for (int unsigned i = 0; i < 16; i++) begin
            exp_pt[i]  = 8'(i * 3 + 1);
            exp_key[i] = 8'(~i);
        end
        load_block(16);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        for (int unsigned i = 0; i < 8; i++) tick;
        check("pt_byte7_before_rst", pt_byte, exp_pt[7]);
        check("key_byte7_before_rst", key_byte, exp_key[7]);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_core_rst_n", core_rst_n, 0);
        check("abort_pt_byte", pt_byte, 0);
        check("abort_key_byte", key_byte, 0);
        check("abort_busy", busy, 0);
        check("abort_stream_first", stream_first, 0);
        check("abort_wr_ready", wr_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
